// File: rtl/alu_sequencer.sv
// Hardwired fetch/decode/execute control unit for register-to-register ALU ops.
// Define ILLEGAL_TRAP_EN to trap undefined opcodes; otherwise they retire as NOPs.
module alu_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int IR_W     = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [IR_W-1:0]     ir,
  input  logic                mem_ready,
  output logic [OPC_W-1:0]    opcode,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                z_in,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                lo_in,
  output logic                hi_in,
  output logic                done,
  output logic                busy,
  output logic                mem_err,
  output logic                illegal
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  logic [3:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_err_q, mem_err_d;
  logic          halt;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_md, is_un, is_def;
  logic       unused_ir;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_bin = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_md  = (op == OP_MUL) || (op == OP_DIV);
  assign is_un  = (op == OP_NEG) || (op == OP_NOT);
  assign is_def = is_bin || is_md || is_un;

  // Out-of-range indices shift the bit off the top, leaving no strobe.
  function automatic logic [NUM_REGS-1:0] sel(input logic [3:0] idx);
    sel = NUM_REGS'(1) << idx;
  endfunction

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign halt    = illegal_q;
  assign illegal = illegal_q;
`else
  assign halt    = 1'b0;
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      S_IDLE: if (run && !halt) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      S_T1: begin
        if (mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == WW'(WAIT_MAX - 1)) begin
          mem_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_T2: begin
        if (is_un)       state_d = S_T4;
        else if (is_def) state_d = S_T3;
`ifdef ILLEGAL_TRAP_EN
        else             state_d = S_T3;
`else
        else             state_d = S_DONE;
`endif
      end
      S_T3: begin
`ifdef ILLEGAL_TRAP_EN
        if (!is_def) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_T4;
        end
`else
        state_d = S_T4;
`endif
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_md ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = run ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    opcode    = '0;
    r_in      = '0;
    r_out     = '0;
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    z_in      = 1'b0;
    pc_in     = 1'b0;
    read      = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    lo_in     = 1'b0;
    hi_in     = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = (wait_q == '0);
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_bin) begin
          r_out = sel(rb);
          y_in  = 1'b1;
        end else if (is_md) begin
          r_out = sel(ra);
          y_in  = 1'b1;
        end
      end
      S_T4: begin
        opcode = OPC_W'(op);
        z_in   = 1'b1;
        r_out  = is_bin ? sel(rc) : sel(rb);
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (is_md) lo_in = 1'b1;
        else       r_in  = sel(ra);
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: per-cycle strobe traces from a spec-level model,
// a latency vector table, and hand sequences for reset, timeout and traps.
module tb_alu_sequencer;

  localparam int NREG  = 16;
  localparam int WMAX  = 15;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in;
    logic mdr_out, ir_in, y_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic done, busy, mem_err, illegal;
  } out_t;

  typedef struct {
    logic [31:0] iv;
    int          waits;
    bit          keep;
    int          lat;
  } vec_t;

  logic        clock, clear, run, mem_ready;
  logic [31:0] ir;
  logic [4:0]  opcode;
  logic [15:0] r_in, r_out;
  logic pc_out, mar_in, inc_pc, z_in, pc_in, read, mdr_in;
  logic mdr_out, ir_in, y_in, zlow_out, zhigh_out, lo_in, hi_in;
  logic done, busy, mem_err, illegal;

  out_t act;
  out_t exp_q[$];
  bit   mr_q[$];
  vec_t tbl[$];

  int n_cmp, n_bad;
  bit m_err, m_ill, idle_pend;

  alu_sequencer #(
    .NUM_REGS(NREG), .OPC_W(5), .IR_W(32), .WAIT_MAX(WMAX)
  ) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .mem_ready(mem_ready), .opcode(opcode),
    .r_in(r_in), .r_out(r_out),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc),
    .z_in(z_in), .pc_in(pc_in), .read(read),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .lo_in(lo_in), .hi_in(hi_in), .done(done), .busy(busy),
    .mem_err(mem_err), .illegal(illegal)
  );

  always #5 clock = ~clock;

  always_comb begin
    act           = '0;
    act.opcode    = opcode;
    act.r_in      = r_in;
    act.r_out     = r_out;
    act.pc_out    = pc_out;
    act.mar_in    = mar_in;
    act.inc_pc    = inc_pc;
    act.z_in      = z_in;
    act.pc_in     = pc_in;
    act.read      = read;
    act.mdr_in    = mdr_in;
    act.mdr_out   = mdr_out;
    act.ir_in     = ir_in;
    act.y_in      = y_in;
    act.zlow_out  = zlow_out;
    act.zhigh_out = zhigh_out;
    act.lo_in     = lo_in;
    act.hi_in     = hi_in;
    act.done      = done;
    act.busy      = busy;
    act.mem_err   = mem_err;
    act.illegal   = illegal;
  end

  task automatic chk(input string nm, input out_t got, input out_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, got, want);
    end
  endtask

  function automatic out_t base();
    out_t e;
    e         = '0;
    e.busy    = 1'b1;
    e.mem_err = m_err;
    e.illegal = m_ill;
    return e;
  endfunction

  function automatic logic [15:0] oh(input int idx);
    logic [15:0] v;
    v = '0;
    if (idx < NREG) v[idx] = 1'b1;
    return v;
  endfunction

  // Expected cycle-by-cycle strobes derived from the instruction class.
  task automatic build(input logic [31:0] iv, input int waits,
                       output bit tmo, output bit trap);
    out_t e;
    int op, ra, rb, rc, nt1;
    bit bin, md, un;
    op  = int'(iv[31:27]);
    ra  = int'(iv[26:23]);
    rb  = int'(iv[22:19]);
    rc  = int'(iv[18:15]);
    bin = (op >= 3) && (op <= 10);
    md  = (op == 15) || (op == 16);
    un  = (op == 17) || (op == 18);
    tmo  = (waits >= WMAX);
    trap = 1'b0;
    e = base();
    e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    exp_q.push_back(e); mr_q.push_back(1'($urandom_range(0, 1)));
    nt1 = tmo ? WMAX : waits + 1;
    for (int j = 0; j < nt1; j++) begin
      e = base();
      e.zlow_out = 1; e.read = 1; e.mdr_in = 1; e.pc_in = (j == 0);
      exp_q.push_back(e); mr_q.push_back(!tmo && (j == waits));
    end
    if (tmo) return;
    e = base();
    e.mdr_out = 1; e.ir_in = 1;
    exp_q.push_back(e); mr_q.push_back(1'($urandom_range(0, 1)));
    if (!(bin || md || un)) begin
`ifdef ILLEGAL_TRAP_EN
      exp_q.push_back(base()); mr_q.push_back(1'b0);
      trap = 1'b1;
      return;
`else
      e = base(); e.done = 1;
      exp_q.push_back(e); mr_q.push_back(1'b0);
      return;
`endif
    end
    if (!un) begin
      e = base();
      e.r_out = bin ? oh(rb) : oh(ra); e.y_in = 1;
      exp_q.push_back(e); mr_q.push_back(1'($urandom_range(0, 1)));
    end
    e = base();
    e.opcode = 5'(op); e.z_in = 1; e.r_out = bin ? oh(rc) : oh(rb);
    exp_q.push_back(e); mr_q.push_back(1'($urandom_range(0, 1)));
    e = base();
    e.zlow_out = 1;
    if (md) e.lo_in = 1;
    else    e.r_in  = oh(ra);
    exp_q.push_back(e); mr_q.push_back(1'($urandom_range(0, 1)));
    if (md) begin
      e = base(); e.zhigh_out = 1; e.hi_in = 1;
      exp_q.push_back(e); mr_q.push_back(1'($urandom_range(0, 1)));
    end
    e = base(); e.done = 1;
    exp_q.push_back(e); mr_q.push_back(1'b0);
  endtask

  task automatic do_instr(input logic [31:0] iv, input int waits, input bit keep,
                          output int lat, output bit ends_idle);
    bit tmo, trap;
    int n;
    exp_q.delete();
    mr_q.delete();
    build(iv, waits, tmo, trap);
    ir  = iv;
    lat = -1;
    n   = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("step", act, exp_q[i]);
      if (act.done && lat < 0) lat = i + 1;
      mem_ready = mr_q[i];
      run = (i == n - 1) ? keep : 1'($urandom_range(0, 1));
    end
    if (tmo)  m_err = 1'b1;
    if (trap) m_ill = 1'b1;
    ends_idle = tmo || trap || !keep;
  endtask

  task automatic issue(input logic [31:0] iv, input int waits, input bit keep,
                       output int lat);
    out_t e;
    bit ei;
    if (idle_pend) begin
      @(negedge clock);
      e = base(); e.busy = 0;
      chk("idle", act, e);
    end
    run = 1'b1;
    do_instr(iv, waits, keep, lat, ei);
    idle_pend = ei;
  endtask

  task automatic do_reset();
    #2;
    clear = 1'b0;
    run   = 1'b0;
    #1;
    chk("reset", act, '0);
    m_err = 1'b0;
    m_ill = 1'b0;
    @(negedge clock);
    clear     = 1'b1;
    idle_pend = 1'b1;
  endtask

  initial begin
    int lat;
    logic [4:0] ops[13];
    out_t e;
    clock = 0; clear = 0; run = 0; mem_ready = 0; ir = '0;
    n_cmp = 0; n_bad = 0; m_err = 0; m_ill = 0; idle_pend = 0;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
            5'd15, 5'd16, 5'd17, 5'd18, 5'd31};

    tbl.push_back('{32'h8A800000, 0,  1'b0, 6});
    tbl.push_back('{32'h19890000, 0,  1'b1, 7});
    tbl.push_back('{32'h7B380000, 0,  1'b1, 8});
    tbl.push_back('{32'h90A00000, 0,  1'b0, 6});
    tbl.push_back('{32'h81480000, 0,  1'b1, 8});
    tbl.push_back('{32'h27F68000, 3,  1'b1, 10});
    tbl.push_back('{32'h40000000, 1,  1'b0, 8});
    tbl.push_back('{32'h19890000, 14, 1'b1, 21});
`ifndef ILLEGAL_TRAP_EN
    tbl.push_back('{32'hF8000000, 0,  1'b1, 4});
    tbl.push_back('{32'h8A800000, 0,  1'b0, 6});
`endif

    #1;
    chk("reset_init", act, '0);
    @(negedge clock);
    clear = 1'b1;

    // Reset arriving in T4 must clear every strobe without a clock.
    run = 1'b1; ir = 32'h19890000; mem_ready = 1'b1;
    repeat (5) @(negedge clock);
    n_cmp++;
    if (opcode !== 5'b00011) begin
      n_bad++;
      $display("FAIL t4_opcode: got %b expected 00011", opcode);
    end
    do_reset();

    foreach (tbl[i]) begin
      issue(tbl[i].iv, tbl[i].waits, tbl[i].keep, lat);
      n_cmp++;
      if (lat != tbl[i].lat) begin
        n_bad++;
        $display("FAIL latency[%0d]: got %0d expected %0d", i, lat, tbl[i].lat);
      end
    end

    issue(32'h19890000, 100, 1'b1, lat);
    n_cmp++;
    if (lat != -1) begin
      n_bad++;
      $display("FAIL timeout_done: got done at %0d expected none", lat);
    end
    issue(32'h8A800000, 0, 1'b1, lat);
    issue(32'h7B380000, 2, 1'b0, lat);
    do_reset();

    for (int k = 0; k < 40; k++) begin
      int sel, w;
      logic [31:0] iv;
`ifdef ILLEGAL_TRAP_EN
      sel = $urandom_range(0, 11);
`else
      sel = $urandom_range(0, 12);
`endif
      iv = {ops[sel], 27'($urandom)};
      w  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      issue(iv, w, 1'($urandom_range(0, 1)), lat);
    end
    do_reset();

`ifdef ILLEGAL_TRAP_EN
    issue(32'hF8000000, 0, 1'b1, lat);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      run = 1'b1;
      e = base(); e.busy = 0;
      chk("halted", act, e);
    end
    do_reset();
    issue(32'h8A800000, 0, 1'b0, lat);
`else
    issue(32'hF8000000, 0, 1'b0, lat);
`endif
    @(negedge clock);
    e = base(); e.busy = 0;
    chk("final_idle", act, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
